fft_16p_twiddle: RTL and testbench
==================================

FFT_16P_TWIDDLE -- requirements
Module: fft_16p_twiddle

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the complex sample component width (signed).
REQ-002 SHALL have parameter CW, default 16, meaning the twiddle coefficient width (signed Q2.14).
REQ-003 SHALL have the following ports; there is one clock, and reset is asynchronous and active-high:
  clk       in   1    rising-edge clock
  rst       in   1    asynchronous, active-high reset
  in_valid  in   1    input sample valid
  in_sof    in   1    first sample of a 16-sample frame (qualified by in_valid)
  in_r      in   DW   input real part, from the upstream 4-point FFT unit
  in_i      in   DW   input imaginary part
  out_valid out  1    output sample valid
  out_sof   out  1    out_sof is in_sof delayed to align with the output sample
  out_r     out  DW   twiddled real part
  out_i     out  DW   twiddled imaginary part

Function
REQ-004 SHALL keep a 4-bit sample index idx that advances by 1 on each accepted sample (in_valid=1) and wraps from 15 to 0.
REQ-005 SHALL treat a sample with in_valid=1 and in_sof=1 as index 0, regardless of the current idx, and set idx to 1 afterwards.
REQ-006 SHALL hold idx unchanged while in_valid=0; gaps of any length are permitted.
REQ-007 SHALL derive g=idx[3:2] and k=idx[1:0], and use twiddle exponent e=g*k, where e is one of {0,1,2,3,4,6,9}.
REQ-008 SHALL use W16^e = cos(2*pi*e/16) - j*sin(2*pi*e/16) in Q2.14, as (wr,wi) pairs:
  e0 (16384,0); e1 (15137,-6270); e2 (11585,-11585); e3 (6270,-15137);
  e4 (0,-16384); e6 (-11585,-11585); e9 (-15137,6270).
REQ-009 SHALL compute full-precision products: pr = in_r*wr - in_i*wi and pi = in_r*wi + in_i*wr, each at least DW+CW+1 bits.
REQ-010 SHALL round each result as (p + 8192) arithmetic-shifted right by 14 (round half up).
REQ-011 SHALL saturate each rounded result to [-32768, 32767].
REQ-012 SHALL have a fixed latency of 2 clock cycles:
  - stage 1 registers the four partial products, e, and the valid/sof flags;
  - stage 2 registers the rounded and saturated sums.
REQ-013 SHALL assert out_valid exactly 2 cycles after each accepted input; out_sof follows the same timing.
REQ-014 SHALL hold out_r and out_i at their last values while out_valid=0.
REQ-015 SHALL have no backpressure: every accepted sample emerges, and a sample may be accepted in every cycle.
REQ-016 SHALL handle simultaneous in_sof with idx=0: the sample is index 0 and no special action is taken.
REQ-017 SHALL handle in_sof mid-frame: the partial frame is abandoned, and samples already in the pipeline complete with their original twiddles.

Reset
REQ-018 SHALL, while rst=1, asynchronously clear idx, all pipeline registers, out_valid, out_sof, out_r and out_i to 0.
REQ-019 SHALL, after rst deasserts mid-frame, start with idx=0; in-flight samples are discarded and no out_valid pulse is produced for them.

Structure
REQ-020 SHALL take DW, CW, the fractional-bit count 14, the twiddle (wr,wi) table and the saturation limits from the shared package fft_pkg.
REQ-021 SHALL place the 2-stage complex multiply, round and saturate logic in sub-module cmul_q14.
REQ-022 SHALL keep the index counter and twiddle selection in fft_16p_twiddle.

Verification
REQ-023 Bench SHALL send sof at idx 0, then stream to idx 5 with value 1000+j0 -> e=1, output 924-j383, two cycles later.
REQ-024 Bench SHALL send -32768-j32768 at idx 6 (e=2) -> out_r=-32768 (saturated), out_i=0.
REQ-025 Bench SHALL send 32767+j32767 at idx 10 (e=4) -> out_r=32767, out_i=-32767.
REQ-026 Bench SHALL send idx 0..3 (e=0) with arbitrary x -> output equals x exactly.
REQ-027 Bench SHALL send 16 samples with in_valid gaps of 0-3 cycles, then a second sof -> out_sof asserted on output samples 0 and 16 only, with all twiddles correct.
REQ-028 Bench SHALL assert rst mid-frame at idx 7 with samples in flight -> outputs 0 and out_valid=0 immediately; the next sample after release uses e=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and the W16 twiddle table for the 16-point radix-4 twiddle stage.
// Coefficients are Q2.14: 16384 represents 1.0.
package fft_pkg;

   localparam int DW_DEF     = 16;
   localparam int CW_DEF     = 16;
   localparam int FRAC_BITS  = 14;
   localparam int ROUND_HALF = 1 << (FRAC_BITS - 1);
   localparam int SAT_MAX    = 32767;
   localparam int SAT_MIN    = -32768;

   typedef struct packed {
      logic [15:0] wr;
      logic [15:0] wi;
   } twiddle_t;

   function automatic twiddle_t tw_pair(input int wr, input int wi);
      twiddle_t t;
      t.wr = 16'(wr);
      t.wi = 16'(wi);
      return t;
   endfunction

   // Only exponents g*k with g,k in 0..3 can occur; anything else falls back to W^0.
   function automatic twiddle_t twiddle_lookup(input logic [3:0] e);
      twiddle_t t;
      case (e)
         4'd1:    t = tw_pair( 15137,  -6270);
         4'd2:    t = tw_pair( 11585, -11585);
         4'd3:    t = tw_pair(  6270, -15137);
         4'd4:    t = tw_pair(     0, -16384);
         4'd6:    t = tw_pair(-11585, -11585);
         4'd9:    t = tw_pair(-15137,   6270);
         default: t = tw_pair( 16384,      0);
      endcase
      return t;
   endfunction

endpackage

// File: rtl/cmul_q14.sv
// Two-stage complex multiply by a Q2.14 coefficient: partial products, then
// round-half-up, arithmetic shift and saturation. Outputs hold when idle.
module cmul_q14
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   input  logic          sof_i,
   input  logic [DW-1:0] xr_i,
   input  logic [DW-1:0] xi_i,
   input  logic [CW-1:0] wr_i,
   input  logic [CW-1:0] wi_i,
   output logic          valid_o,
   output logic          sof_o,
   output logic [DW-1:0] yr_o,
   output logic [DW-1:0] yi_o
);

   localparam int PW = DW + CW;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] HALF_C = SW'(ROUND_HALF);
   localparam logic signed [SW-1:0] MAX_C  = SW'(SAT_MAX);
   localparam logic signed [SW-1:0] MIN_C  = SW'(SAT_MIN);

   logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic                 v1_q, sof1_q, v2_q, sof2_q;
   logic        [DW-1:0] yr_q, yi_q;
   logic signed [SW-1:0] sum_r, sum_i;
   logic        [DW-1:0] yr_d, yi_d;

   function automatic logic [DW-1:0] round_sat(input logic signed [SW-1:0] p);
      logic signed [SW-1:0] r;
      r = (p + HALF_C) >>> FRAC_BITS;
      if (r > MAX_C) return DW'(MAX_C);
      if (r < MIN_C) return DW'(MIN_C);
      return r[DW-1:0];
   endfunction

   always_comb begin
      sum_r = SW'(p_rr_q) - SW'(p_ii_q);
      sum_i = SW'(p_ri_q) + SW'(p_ir_q);
      yr_d  = round_sat(sum_r);
      yi_d  = round_sat(sum_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_rr_q <= '0;
         p_ii_q <= '0;
         p_ri_q <= '0;
         p_ir_q <= '0;
         v1_q   <= 1'b0;
         sof1_q <= 1'b0;
         v2_q   <= 1'b0;
         sof2_q <= 1'b0;
         yr_q   <= '0;
         yi_q   <= '0;
      end else begin
         v1_q   <= valid_i;
         sof1_q <= valid_i & sof_i;
         if (valid_i) begin
            p_rr_q <= PW'($signed(xr_i)) * PW'($signed(wr_i));
            p_ii_q <= PW'($signed(xi_i)) * PW'($signed(wi_i));
            p_ri_q <= PW'($signed(xr_i)) * PW'($signed(wi_i));
            p_ir_q <= PW'($signed(xi_i)) * PW'($signed(wr_i));
         end
         v2_q   <= v1_q;
         sof2_q <= sof1_q;
         if (v1_q) begin
            yr_q <= yr_d;
            yi_q <= yi_d;
         end
      end
   end

   assign valid_o = v2_q;
   assign sof_o   = sof2_q;
   assign yr_o    = yr_q;
   assign yi_o    = yi_q;

endmodule

// File: rtl/fft_16p_twiddle.sv
// Inter-stage twiddle for a 16-point FFT built from 4-point units: tracks the
// sample index within a frame and multiplies each sample by W16^(g*k).
module fft_16p_twiddle
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_sof,
   input  logic [DW-1:0] in_r,
   input  logic [DW-1:0] in_i,
   output logic          out_valid,
   output logic          out_sof,
   output logic [DW-1:0] out_r,
   output logic [DW-1:0] out_i
);

   logic [3:0]    idx_q, idx_d, cur_idx, e;
   twiddle_t      tw;
   logic [CW-1:0] w_r, w_i;

   // A start-of-frame sample is index 0 no matter where the counter was.
   always_comb begin
      cur_idx = (in_valid && in_sof) ? 4'd0 : idx_q;
      idx_d   = in_valid ? cur_idx + 4'd1 : idx_q;
      e       = {2'b00, cur_idx[3:2]} * {2'b00, cur_idx[1:0]};
      tw      = twiddle_lookup(e);
      w_r     = CW'($signed(tw.wr));
      w_i     = CW'($signed(tw.wi));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idx_q <= 4'd0;
      else     idx_q <= idx_d;
   end

   cmul_q14 #(
      .DW (DW),
      .CW (CW)
   ) u_cmul (
      .clk     (clk),
      .rst     (rst),
      .valid_i (in_valid),
      .sof_i   (in_sof),
      .xr_i    (in_r),
      .xi_i    (in_i),
      .wr_i    (w_r),
      .wi_i    (w_i),
      .valid_o (out_valid),
      .sof_o   (out_sof),
      .yr_o    (out_r),
      .yi_o    (out_i)
   );

endmodule

// File: tb/tb_fft_16p_twiddle.sv
// Directed bench for fft_16p_twiddle: hand-computed expected outputs per frame
// index, checked in order by a monitor that also checks latency and sof.
module tb_fft_16p_twiddle;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [DW-1:0] in_r = '0;
   logic [DW-1:0] in_i = '0;
   logic          out_valid, out_sof;
   logic [DW-1:0] out_r, out_i;

   typedef struct {
      int r;
      int i;
      int sof;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_r = 0;
   int   last_i = 0;

   // Inputs per frame index and the hand-computed twiddled results.
   int vr[16] = '{123, -32768, 0, -1, 500, 1000, -32768, 2000, -7, 100, 32767, 1000, 32767, 0, -1000, 1000};
   int vi[16] = '{-456, 32767, 7, 1, -500, 0, -32768, 1000, 9, 100, 32767, 0, -32768, 1000, 1000, 0};
   int er[16] = '{123, -32768, 0, -1, 500, 924, -32768, 1689, -7, 141, 32767, -707, 32767, 924, 1414, -924};
   int ei[16] = '{-456, 32767, 7, 1, -500, -383, 0, -1465, 9, 0, -32767, -707, -32768, 383, 0, 383};

   fft_16p_twiddle #(.DW(DW), .CW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_r     (out_r),
      .out_i     (out_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int r, input int i, input bit sof, input int xr, input int xi);
      exp_t e;
      in_valid = 1'b1;
      in_sof   = sof;
      in_r     = DW'(r);
      in_i     = DW'(i);
      e.r = xr;
      e.i = xi;
      e.sof = int'(sof);
      e.due = cyc + 2;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_idx(input int n, input bit sof);
      send(vr[n], vi[n], sof, er[n], ei[n]);
   endtask

   // Output monitor: one line per output sample.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (out_valid) begin
            $display("out cyc=%0d r=%0d i=%0d sof=%0d", cyc, $signed(out_r), $signed(out_i), out_sof);
            if (exp_q.size() == 0) begin
               check("spurious_valid", int'(out_valid), 0);
            end else begin
               e = exp_q.pop_front();
               check("out_r", $signed(out_r), e.r);
               check("out_i", $signed(out_i), e.i);
               check("out_sof", int'(out_sof), e.sof);
               check("latency", cyc, e.due);
               last_r = e.r;
               last_i = e.i;
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            check("missing_out", int'(out_valid), 1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_sof", int'(out_sof), 0);
      check("rst_r", $signed(out_r), 0);
      check("rst_i", $signed(out_i), 0);
      rst = 1'b0;
      idle(2);

      // Back-to-back frame, then one wrapped sample without sof (index 0 again).
      for (int n = 0; n < 16; n++) send_idx(n, n == 0);
      send(5, 5, 1'b0, 5, 5);
      idle(5);
      check("hold_r", $signed(out_r), last_r);
      check("hold_i", $signed(out_i), last_i);
      check("hold_valid", int'(out_valid), 0);

      // Frame with 0-3 cycle gaps, closed by a new sof.
      for (int n = 0; n < 16; n++) begin
         send_idx(n, n == 0);
         idle(n % 4);
      end
      send_idx(0, 1'b1);

      // Mid-frame sof right behind index 5: the index-5 sample keeps its twiddle.
      for (int n = 1; n < 6; n++) send_idx(n, 1'b0);
      send(1000, 0, 1'b1, 1000, 0);
      send_idx(1, 1'b0);
      idle(4);

      // Reset with the counter at 7 and samples in flight.
      for (int n = 0; n < 7; n++) send_idx(n, n == 0);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_r", $signed(out_r), 0);
      check("midrst_i", $signed(out_i), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      send(1000, 0, 1'b0, 1000, 0);
      send(2000, 1000, 1'b0, 2000, 1000);
      idle(5);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
